seg_display_reader: RTL and testbench
=====================================

# seg_display_reader

Recovers BCD digits from a multiplexed, active-low 7-segment display bus (segment lines plus one-hot active-low digit strobes) and presents them as a parallel digit word with a frame strobe. It is the inverse of the BCD-to-segment decoding path in the frequency-meter display chain. It sits on the observation side, allowing a self-check bench or a readback path to confirm what the display actually shows.

## Interface

Parameters:

- NUM_DIGITS, 6: number of multiplexed digit positions; width of the strobe bus.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..15.

Ports:

- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- seg_in, input, 7: active-low segments. Bit 6 = a, bit 5 = b, …, bit 0 = g.
- digit_sel, input, NUM_DIGITS: active-low one-hot digit strobe; bit i selects digit i, with digit 0 least significant.
- bcd_out, output, 4*NUM_DIGITS: recovered digits; nibble i holds digit i.
- digit_err, output, NUM_DIGITS: per-digit flag; the pattern last captured for that digit was unrecognized.
- frame_valid, output, 1: one-cycle pulse; bcd_out and digit_err were updated with a complete frame.
- frame_err, output, 1: valid only with frame_valid; OR of digit_err for that frame.

## Operation

- Input stage:
  - seg_in and digit_sel are registered once (sample stage) before any use.
  - A sample is well-formed only if exactly one digit_sel bit is 0.
- Stability counter, 4 bits, saturating at STABLE_CYCLES-1:
  - Cleared when the current sample differs from the previous sample in either seg or sel.
  - Cleared when the current sample is not well-formed.
  - Otherwise increments.
- Capture:
  - Occurs on the edge where the counter equals STABLE_CYCLES-1 and the dwell-captured flag is clear.
  - The capture then sets the dwell-captured flag.
  - The flag clears whenever the counter clears, so each strobe dwell produces at most one capture.
- Pattern decode on capture (seg, active-low):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4.
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111→4'hF (blank; legal, not an error).
  - Any other pattern→4'hE, with that digit's error bit set.
- Captured nibble and error bit go to a shadow slot for the selected digit, and the digit's bit is set in a seen-mask.
- A repeat capture of the same digit before frame completion overwrites its shadow slot (latest wins).
- Frame completion:
  - Triggered when a capture makes the seen-mask all ones.
  - On the next edge, shadow→bcd_out/digit_err, frame_valid=1, frame_err=OR of shadow errors.
  - The seen-mask clears on that same edge.
  - Outputs hold until the next frame; partial frames never reach the outputs.
- Reset (rst_n=0 at an edge), including mid-dwell or mid-frame:
  - bcd_out = all 4'hF; digit_err = 0; frame_valid = 0; frame_err = 0.
  - Seen-mask, counter, dwell flag and sample registers cleared; shadow = all 4'hF.

## Timing

- Input change at edge k: the value is first in the sample register after edge k.
- Capture occurs at edge k+STABLE_CYCLES, given stable and well-formed input from edge k onward.
- frame_valid is high for exactly the cycle after the edge that captures the last missing digit.
- Minimum dwell per digit for a capture: STABLE_CYCLES cycles. Shorter dwells are ignored silently.
- A glitch on seg_in mid-dwell restarts the count.
  - If the dwell was already captured, the post-glitch value is captured again after STABLE_CYCLES stable samples, and it overwrites the slot.
- frame_valid never asserts on two consecutive cycles; a new frame needs NUM_DIGITS further captures.
- The first cycle after rst_n rises: no capture is possible before edge STABLE_CYCLES+1.

## Test plan

- Clean scan:
  - Stimulus: drive digits 0..5 with patterns for 1,2,3,4,5,6, each dwell 8 cycles.
  - Required: one frame_valid one cycle after digit 5's capture edge; bcd_out=24'h654321; frame_err=0.
- Full decode table:
  - Stimulus: digit 0 driven successively with 0..9, blank, and 0110000; the other digits held at 0000001.
  - Required: nibble 0 equals 0..9, then F, then E with digit_err[0]=1 and frame_err=1.
- Short dwell and glitch:
  - Stimulus: digit 2 dwell of 3 cycles with STABLE_CYCLES=4.
    - Required: no capture; no frame.
  - Stimulus: a 1-cycle seg glitch inside an 8-cycle dwell.
    - Required: the final value is captured.
- Malformed strobes:
  - Stimulus: digit_sel=6'b111111 or 6'b111100 held for 10 cycles.
  - Required: no capture; seen-mask unchanged; outputs hold.
- Repeat capture:
  - Stimulus: digit 3 shown as 7 and then as 8 before digits 4 and 5 arrive.
  - Required: completed frame has nibble 3 = 8.
- Reset mid-frame:
  - Stimulus: rst_n low for 1 cycle after 4 of 6 digits captured.
  - Required: bcd_out=24'hFFFFFF and no frame_valid until six fresh captures.

Source files
------------

// File: rtl/seg_display_reader.sv
// seg_display_reader
//   Recovers BCD digits from a multiplexed, active-low 7-segment display bus.
//   Each digit strobe dwell that stays stable and well-formed for
//   STABLE_CYCLES samples is decoded once into a shadow slot. When every
//   digit has been seen, the shadow is published on bcd_out/digit_err with a
//   one-cycle frame_valid pulse.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   seg_in       active-low segments, bit 6 = a ... bit 0 = g
//   digit_sel    active-low one-hot digit strobe, bit i = digit i
//   bcd_out      recovered digits, nibble i = digit i (blank = F, unknown = E)
//   digit_err    per-digit flag: last captured pattern was unrecognized
//   frame_valid  one-cycle pulse when bcd_out/digit_err take a complete frame
//   frame_err    OR of digit_err for the frame, meaningful with frame_valid
module seg_display_reader #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  logic [6:0]            seg_q;
  logic [6:0]            seg_prev;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [NUM_DIGITS-1:0] sel_prev;
  logic [3:0]            stable_cnt;
  logic [3:0]            stable_cnt_next;
  logic                  captured;
  logic                  capture;
  logic                  well_formed;
  logic                  same_sample;
  logic [3:0]            dec_nib;
  logic                  dec_err;
  logic [3:0]            shadow_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_err;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  frame_pend;

  always_comb begin
    well_formed = $onehot(~sel_q);
    same_sample = (seg_q == seg_prev) && (sel_q == sel_prev);

    stable_cnt_next = 4'd0;
    if (well_formed && same_sample) begin
      if (stable_cnt == CNT_MAX) stable_cnt_next = CNT_MAX;
      else                       stable_cnt_next = stable_cnt + 4'd1;
    end

    // The dwell flag blocks a second capture while the counter sits saturated.
    capture = well_formed && (stable_cnt_next == CNT_MAX) && !captured;

    // Publishing a frame empties the mask on the same edge; a capture on that
    // edge (not reachable with STABLE_CYCLES >= 2) would still be kept.
    seen_next = (frame_pend ? '0 : seen) | (capture ? ~sel_q : '0);
  end

  always_comb begin
    dec_err = 1'b0;
    dec_nib = 4'hE;
    case (seg_q)
      7'b0000001: dec_nib = 4'd0;
      7'b1001111: dec_nib = 4'd1;
      7'b0010010: dec_nib = 4'd2;
      7'b0000110: dec_nib = 4'd3;
      7'b1001100: dec_nib = 4'd4;
      7'b0100100: dec_nib = 4'd5;
      7'b0100000: dec_nib = 4'd6;
      7'b0001111: dec_nib = 4'd7;
      7'b0000000: dec_nib = 4'd8;
      7'b0000100: dec_nib = 4'd9;
      7'b1111111: dec_nib = 4'hF;
      default:    dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q       <= '0;
      seg_prev    <= '0;
      sel_q       <= '0;
      sel_prev    <= '0;
      stable_cnt  <= '0;
      captured    <= 1'b0;
      seen        <= '0;
      frame_pend  <= 1'b0;
      shadow_err  <= '0;
      bcd_out     <= '1;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_nib[i] <= 4'hF;
    end else begin
      seg_q      <= seg_in;
      sel_q      <= digit_sel;
      seg_prev   <= seg_q;
      sel_prev   <= sel_q;
      stable_cnt <= stable_cnt_next;

      if (stable_cnt_next == 4'd0) captured <= 1'b0;
      else if (capture)            captured <= 1'b1;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && !sel_q[i]) begin
          shadow_nib[i] <= dec_nib;
          shadow_err[i] <= dec_err;
        end
      end

      seen        <= seen_next;
      frame_pend  <= capture && (&seen_next);
      frame_valid <= frame_pend;
      frame_err   <= frame_pend && (|shadow_err);

      if (frame_pend) begin
        for (int i = 0; i < NUM_DIGITS; i++) bcd_out[4*i +: 4] <= shadow_nib[i];
        digit_err <= shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_reader.sv
module tb_seg_display_reader;

  localparam int ND = 6;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_in = 7'h7F;
  logic [ND-1:0]   digit_sel = '1;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   digit_err;
  logic            frame_valid;
  logic            frame_err;

  seg_display_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_sel(digit_sel),
    .bcd_out(bcd_out), .digit_err(digit_err),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // Reference model: a digit is captured once per run of SC identical,
  // well-formed samples; a frame is published the edge after all digits seen.
  logic [3:0]      m_shadow [ND];
  logic [ND-1:0]   m_sherr;
  logic [4*ND-1:0] m_bcd;
  logic [ND-1:0]   m_err;
  logic            m_fv, m_ferr, m_pend;
  logic [ND-1:0]   m_seen;
  logic [6:0]      m_seg;
  logic [ND-1:0]   m_sel;
  int              m_run;

  int obs_fv = 0, exp_fv = 0, obs_fv_cyc = -1, exp_fv_cyc = -1;
  logic obs_ferr = 1'b0;
  int diverge = 0, first_div = -1;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (s == seg_tab[v]) return {1'b0, 4'(v)};
    if (s == 7'h7F) return 5'h0F;
    return 5'h1E;
  endfunction

  function automatic bit ref_wf(input logic [ND-1:0] sel);
    return $countones(~sel) == 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_shadow[i] = 4'hF;
    m_sherr = '0; m_bcd = '1; m_err = '0; m_fv = 0; m_ferr = 0; m_pend = 0;
    m_seen = '0; m_seg = '0; m_sel = '0; m_run = 0;
  endtask

  task automatic model_edge(input logic rst, input logic [6:0] s, input logic [ND-1:0] d);
    logic [4:0] dec;
    if (!rst) begin
      model_reset();
      return;
    end
    m_fv = 0;
    m_ferr = 0;
    if (m_pend) begin
      for (int i = 0; i < ND; i++) m_bcd[4*i +: 4] = m_shadow[i];
      m_err = m_sherr;
      m_fv = 1;
      m_ferr = |m_sherr;
      m_seen = '0;
      m_pend = 0;
    end
    if (m_run == SC) begin
      dec = ref_decode(m_seg);
      for (int i = 0; i < ND; i++) begin
        if (!m_sel[i]) begin
          m_shadow[i] = dec[3:0];
          m_sherr[i] = dec[4];
          m_seen[i] = 1'b1;
        end
      end
      if (&m_seen) m_pend = 1;
    end
    if (ref_wf(d) && s == m_seg && d == m_sel) begin
      if (m_run <= SC) m_run++;
    end else begin
      m_run = ref_wf(d) ? 1 : 0;
    end
    m_seg = s;
    m_sel = d;
  endtask

  task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input int n);
    repeat (n) begin
      seg_in = s;
      digit_sel = d;
      @(posedge clk);
      cyc++;
      model_edge(rst_n, s, d);
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        obs_fv++;
        obs_fv_cyc = cyc;
        obs_ferr = frame_err;
      end
      if (m_fv) begin
        exp_fv++;
        exp_fv_cyc = cyc;
      end
      if (bcd_out !== m_bcd || digit_err !== m_err || frame_valid !== m_fv ||
          (m_fv && frame_err !== m_ferr)) begin
        diverge++;
        if (first_div < 0) first_div = cyc;
      end
    end
  endtask

  function automatic logic [ND-1:0] sel_of(input int digit);
    logic [ND-1:0] oh;
    oh = '0;
    oh[digit] = 1'b1;
    return ~oh;
  endfunction

  task automatic show(input int digit, input int val, input int n);
    step(seg_tab[val], sel_of(digit), n);
  endtask

  task automatic idle(input int n);
    step(7'h7F, '1, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    checks++; if (bcd_out !== 24'hFFFFFF) begin errors++; $display("FAIL reset_bcd got %h want ffffff", bcd_out); end
    checks++; if (digit_err !== '0) begin errors++; $display("FAIL reset_digit_err got %b want 0", digit_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
  endtask

  task automatic test_clean_scan();
    int f0, d0;
    f0 = obs_fv; d0 = diverge;
    for (int d = 0; d < ND; d++) show(d, d + 1, 8);
    idle(2);
    checks++; if (obs_fv - f0 !== 1) begin errors++; $display("FAIL clean_frames got %0d want 1", obs_fv - f0); end
    checks++; if (bcd_out !== 24'h654321) begin errors++; $display("FAIL clean_bcd got %h want 654321", bcd_out); end
    checks++; if (obs_ferr !== 1'b0) begin errors++; $display("FAIL clean_frame_err got %b want 0", obs_ferr); end
    checks++; if (obs_fv_cyc !== exp_fv_cyc) begin errors++; $display("FAIL clean_fv_cycle got %0d want %0d", obs_fv_cyc, exp_fv_cyc); end
    checks++; if (diverge !== d0) begin errors++; $display("FAIL clean_model got %0d divergent cycles want 0 (first %0d)", diverge - d0, first_div); end
  endtask

  task automatic test_decode_table();
    logic [6:0] pat;
    logic [3:0] want;
    int f0;
    for (int v = 0; v < 12; v++) begin
      pat = (v < 10) ? seg_tab[v] : (v == 10) ? 7'b1111111 : 7'b0110000;
      want = (v < 10) ? 4'(v) : (v == 10) ? 4'hF : 4'hE;
      f0 = obs_fv;
      step(pat, sel_of(0), 6);
      for (int d = 1; d < ND; d++) show(d, 0, 6);
      idle(2);
      checks++; if (obs_fv - f0 !== 1 || bcd_out[3:0] !== want)
        begin errors++; $display("FAIL decode_nib v=%0d got %h frames %0d want %h", v, bcd_out[3:0], obs_fv - f0, want); end
      checks++; if (digit_err[0] !== (v == 11))
        begin errors++; $display("FAIL decode_err v=%0d got %b want %b", v, digit_err[0], v == 11); end
      checks++; if (obs_ferr !== (v == 11))
        begin errors++; $display("FAIL decode_frame_err v=%0d got %b want %b", v, obs_ferr, v == 11); end
    end
  endtask

  task automatic test_short_dwell_glitch();
    int f0;
    f0 = obs_fv;
    show(2, 3, 3);
    idle(5);
    show(0, 1, 6); show(1, 2, 6); show(3, 4, 6); show(4, 5, 6); show(5, 6, 6);
    idle(3);
    checks++; if (obs_fv !== f0) begin errors++; $display("FAIL short_dwell frames got %0d want 0", obs_fv - f0); end
    show(2, 9, 3);
    show(2, 8, 1);
    show(2, 9, 4);
    idle(3);
    checks++; if (obs_fv - f0 !== 1) begin errors++; $display("FAIL glitch_frames got %0d want 1", obs_fv - f0); end
    checks++; if (bcd_out !== 24'h654921) begin errors++; $display("FAIL glitch_bcd got %h want 654921", bcd_out); end
  endtask

  task automatic test_malformed();
    int f0;
    logic [4*ND-1:0] hold;
    f0 = obs_fv;
    hold = bcd_out;
    show(0, 5, 8);
    step(seg_tab[3], 6'b111111, 10);
    step(seg_tab[3], 6'b111100, 10);
    checks++; if (bcd_out !== hold || obs_fv !== f0)
      begin errors++; $display("FAIL malformed_hold got %h frames %0d want %h frames 0", bcd_out, obs_fv - f0, hold); end
    for (int d = 1; d < ND; d++) show(d, 7, 6);
    idle(2);
    checks++; if (bcd_out !== 24'h777775 || obs_fv - f0 !== 1)
      begin errors++; $display("FAIL malformed_seen got %h frames %0d want 777775 frames 1", bcd_out, obs_fv - f0); end
  endtask

  task automatic test_repeat();
    int f0;
    f0 = obs_fv;
    for (int d = 0; d < 3; d++) show(d, 0, 6);
    show(3, 7, 8);
    show(3, 8, 8);
    show(4, 1, 6); show(5, 1, 6);
    idle(2);
    checks++; if (bcd_out[15:12] !== 4'd8 || obs_fv - f0 !== 1)
      begin errors++; $display("FAIL repeat_nib3 got %h frames %0d want 8 frames 1", bcd_out[15:12], obs_fv - f0); end
    checks++; if (bcd_out !== 24'h118000) begin errors++; $display("FAIL repeat_bcd got %h want 118000", bcd_out); end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    for (int d = 0; d < 4; d++) show(d, 2, 6);
    rst_n = 1'b0;
    show(3, 2, 1);
    rst_n = 1'b1;
    checks++; if (bcd_out !== 24'hFFFFFF || frame_valid !== 1'b0)
      begin errors++; $display("FAIL midrst_bcd got %h fv %b want ffffff fv 0", bcd_out, frame_valid); end
    f0 = obs_fv;
    show(4, 3, 6); show(5, 3, 6);
    idle(3);
    checks++; if (obs_fv !== f0) begin errors++; $display("FAIL midrst_partial frames got %0d want 0", obs_fv - f0); end
    for (int d = 0; d < 4; d++) show(d, 4, 6);
    idle(2);
    checks++; if (bcd_out !== 24'h334444 || obs_fv - f0 !== 1)
      begin errors++; $display("FAIL midrst_frame got %h frames %0d want 334444 frames 1", bcd_out, obs_fv - f0); end
  endtask

  task automatic test_random();
    int d0, f0, e0, r;
    logic [6:0] pat;
    logic [ND-1:0] sel;
    d0 = diverge; f0 = obs_fv; e0 = exp_fv;
    for (int k = 0; k < 300; k++) begin
      sel = ($urandom_range(0, 9) == 0) ? ND'($urandom) : sel_of($urandom_range(0, ND - 1));
      r = $urandom_range(0, 13);
      pat = (r < 10) ? seg_tab[r] : (r == 10) ? 7'h7F : 7'($urandom);
      step(pat, sel, $urandom_range(1, 10));
      if ($urandom_range(0, 5) == 0) begin
        step(pat ^ (7'd1 << $urandom_range(0, 6)), sel, 1);
        step(pat, sel, $urandom_range(1, 8));
      end
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end
    end
    idle(4);
    checks++; if (diverge !== d0) begin errors++; $display("FAIL random_model got %0d divergent cycles want 0 (first %0d)", diverge - d0, first_div); end
    checks++; if (obs_fv - f0 !== exp_fv - e0) begin errors++; $display("FAIL random_frames got %0d want %0d", obs_fv - f0, exp_fv - e0); end
    checks++; if (bcd_out !== m_bcd || digit_err !== m_err)
      begin errors++; $display("FAIL random_final got %h/%b want %h/%b", bcd_out, digit_err, m_bcd, m_err); end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_scan();
    test_decode_table();
    test_short_dwell_glitch();
    test_malformed();
    test_repeat();
    test_reset_mid_frame();
    test_random();
    checks++; if (diverge !== 0) begin errors++; $display("FAIL overall_model got %0d divergent cycles want 0 (first %0d)", diverge, first_div); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
